bcd_bin_convert: RTL

Sequential converter between binary and packed BCD. It is the inverse companion of the combinational BCD add/subtract path in the CPU datapath. Binary-to-BCD uses shift-and-add-3 (double dabble); BCD-to-binary uses shift-and-subtract-3 (reverse double dabble). One conversion runs at a time, under a start/done handshake. Its flags output uses the same zero/carry bit positions as the BCD arithmetic flags, so the CPU can merge them directly.

---
 rtl/bcd_bin_convert_if.sv | 20 ++
 rtl/bcd_bin_convert.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/bcd_bin_convert_if.sv
// rtl/bcd_bin_convert_if.sv - start/done handshake and result bus of the BCD/binary converter
interface bcd_bin_convert_if;
  logic        start;
  logic        mode;
  logic [11:0] din;
  logic        busy;
  logic        done;
  logic [11:0] dout;
  logic [3:0]  flags;

  modport master (
    output start, mode, din,
    input  busy, done, dout, flags
  );

  modport slave (
    input  start, mode, din,
    output busy, done, dout, flags
  );
endinterface

// File: rtl/bcd_bin_convert.sv
// rtl/bcd_bin_convert.sv - sequential 8-bit binary <-> 3-digit packed BCD converter
// Double dabble for binary->BCD, reverse double dabble for BCD->binary, 10 iterations each.
module bcd_bin_convert (
  input  logic             i_clk,
  input  logic             i_reset,
  bcd_bin_convert_if.slave io_conv
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      r_state;
  logic        r_mode;
  logic        r_invalid;
  logic        r_busy;
  logic        r_done;
  logic [3:0]  r_cnt;
  logic [11:0] r_bcd;
  logic [9:0]  r_bin;
  logic [11:0] r_dout;
  logic [3:0]  r_flags;

  logic [21:0] w_shift;
  logic [11:0] w_bcd_next;
  logic [9:0]  w_bin_next;
  logic [11:0] w_result;
  logic        w_overflow;
  logic [3:0]  w_flags;
  logic        w_load_invalid;

  function automatic logic [11:0] add3_digits(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    for (int d = 0; d < 3; d++) begin
      if (v[4*d +: 4] >= 4'd5) r[4*d +: 4] = v[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [11:0] sub3_digits(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    for (int d = 0; d < 3; d++) begin
      if (v[4*d +: 4] >= 4'd8) r[4*d +: 4] = v[4*d +: 4] - 4'd3;
    end
    return r;
  endfunction

  function automatic logic any_digit_above_9(input logic [11:0] v);
    return (v[11:8] > 4'd9) || (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
  endfunction

  always_comb begin
    w_shift    = '0;
    w_bcd_next = '0;
    w_bin_next = '0;
    if (!r_mode) begin
      w_shift    = {add3_digits(r_bcd), r_bin} << 1;
      w_bcd_next = w_shift[21:10];
      w_bin_next = w_shift[9:0];
    end else begin
      w_shift    = {r_bcd, r_bin} >> 1;
      w_bcd_next = sub3_digits(w_shift[21:10]);
      w_bin_next = w_shift[9:0];
    end
  end

  // Final-iteration values; an invalid BCD operand reports zero and never overflow.
  always_comb begin
    w_result   = '0;
    w_overflow = 1'b0;
    if (!r_mode) begin
      w_result = w_bcd_next;
    end else if (!r_invalid) begin
      w_result   = {2'b00, w_bin_next};
      w_overflow = (w_bin_next > 10'd255);
    end
    w_flags = {1'b0, r_invalid, w_overflow, (w_result == 12'h000)};
  end

  assign w_load_invalid = io_conv.mode && any_digit_above_9(io_conv.din);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_mode    <= 1'b0;
      r_invalid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cnt     <= 4'd0;
      r_bcd     <= 12'h000;
      r_bin     <= 10'h000;
      r_dout    <= 12'h000;
      r_flags   <= 4'h0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (io_conv.start) begin
            r_state   <= S_RUN;
            r_busy    <= 1'b1;
            r_mode    <= io_conv.mode;
            r_invalid <= w_load_invalid;
            r_cnt     <= 4'd0;
            if (io_conv.mode) begin
              r_bcd <= io_conv.din;
              r_bin <= 10'h000;
            end else begin
              r_bcd <= 12'h000;
              r_bin <= {2'b00, io_conv.din[7:0]};
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_bcd <= w_bcd_next;
          r_bin <= w_bin_next;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd9) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_dout  <= w_result;
            r_flags <= w_flags;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign io_conv.busy  = r_busy;
  assign io_conv.done  = r_done;
  assign io_conv.dout  = r_dout;
  assign io_conv.flags = r_flags;

endmodule
